// File: rtl/note_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// note_fetch_scheduler
//   Shares one note-time BRAM between all per-lane note trackers. Each lane
//   raises metadata_request when it needs its next note time. A round-robin
//   arbiter picks one pending lane per service. It reads that lane's current
//   slot from the BRAM, writes the 16-bit time into the lane's metadata_link
//   field and pulses that lane's metadata_available bit for one cycle.
//   One service takes three cycles: ARB, READ and WRITE.
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   enable              new services may start (song running)
//   rewind              synchronous pulse: restart every lane at entry 0
//   metadata_request    per-lane request level; a rising edge queues a fetch
//   metadata_available  one-cycle pulse on the lane whose link was just written
//   metadata_link       lane i note time at [i*TIME_W +: TIME_W]
//   lane_done           lane read a zero end marker or its last entry
//   bram_addr           {lane, slot} to the BRAM address port
//   bram_dout           BRAM read data, one cycle after bram_addr
//   busy                a service is in progress (FSM not idle)
// -----------------------------------------------------------------------------
module note_fetch_scheduler #(
    parameter int NUM_LANES = 37,
    parameter int LANE_W    = 6,
    parameter int SLOTS_LOG = 4,
    parameter int TIME_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          rewind,
    input  logic [NUM_LANES-1:0]          metadata_request,
    output logic [NUM_LANES-1:0]          metadata_available,
    output logic [NUM_LANES*TIME_W-1:0]   metadata_link,
    output logic [NUM_LANES-1:0]          lane_done,
    output logic [LANE_W+SLOTS_LOG-1:0]   bram_addr,
    input  logic [TIME_W-1:0]             bram_dout,
    output logic                          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_READ,
        S_WRITE
    } state_e;

    localparam logic [SLOTS_LOG-1:0] SLOT_MAX  = '1;
    localparam logic [LANE_W:0]      LANES_EXT = (LANE_W+1)'(NUM_LANES);
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_e                         state_q;
    logic [NUM_LANES-1:0]           req_q;
    logic [NUM_LANES-1:0]           pending_q;
    logic [NUM_LANES-1:0]           pending_d;
    logic [LANE_W-1:0]              rr_ptr_q;
    logic [LANE_W-1:0]              grant_q;
    logic [LANE_W+SLOTS_LOG-1:0]    bram_addr_q;
    logic [SLOTS_LOG-1:0]           slot_q [NUM_LANES];
    logic [NUM_LANES-1:0]           lane_done_q;
    logic [NUM_LANES*TIME_W-1:0]    link_q;
    logic [NUM_LANES-1:0]           avail_q;

    logic [NUM_LANES-1:0]           rise;
    logic [NUM_LANES-1:0]           grant_clr;
    logic                           any_pending;
    logic                           grant_found;
    logic [LANE_W-1:0]              grant_idx;
    logic [LANE_W:0]                cand_sum;
    logic [LANE_W-1:0]              cand;
    logic [LANE_W-1:0]              rr_next;
    logic [SLOTS_LOG-1:0]           cur_slot;
    logic                           slot_last;

    // Round-robin search: scan pending lanes starting at rr_ptr, wrapping at
    // NUM_LANES so that nonexistent lane indices are never considered.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (LANE_W+1)'(i);
            if (cand_sum >= LANES_EXT) begin
                cand_sum = cand_sum - LANES_EXT;
            end
            cand = cand_sum[LANE_W-1:0];
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A rising request edge on the lane being granted this cycle is a fresh
    // request, so the set term is applied after the grant clears its bit.
    always_comb begin
        rise        = metadata_request & ~req_q;
        any_pending = |pending_q;
        grant_clr   = '0;
        if (state_q == S_ARB) begin
            grant_clr = NUM_LANES'(1) << grant_idx;
        end
        pending_d = (pending_q & ~grant_clr) | rise;
        rr_next   = (grant_idx == LAST_LANE) ? '0 : grant_idx + 1'b1;
        cur_slot  = slot_q[grant_q];
        slot_last = (cur_slot == SLOT_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            bram_addr_q <= '0;
            lane_done_q <= '0;
            link_q      <= '0;
            avail_q     <= '0;
            // NOTE: the slot pointers are small flops, not RAM, and must start
            // at entry 0, so this array is reset explicitly.
            for (int i = 0; i < NUM_LANES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            req_q   <= metadata_request;
            avail_q <= '0;
            if (rewind) begin
                // Abort any service in flight; links keep their last values.
                state_q     <= S_IDLE;
                pending_q   <= '0;
                rr_ptr_q    <= '0;
                lane_done_q <= '0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    slot_q[i] <= '0;
                end
            end else begin
                pending_q <= pending_d;
                unique case (state_q)
                    S_IDLE: begin
                        if (enable && any_pending) begin
                            state_q <= S_ARB;
                        end
                    end
                    S_ARB: begin
                        grant_q     <= grant_idx;
                        bram_addr_q <= {grant_idx, slot_q[grant_idx]};
                        rr_ptr_q    <= rr_next;
                        state_q     <= S_READ;
                    end
                    S_READ: begin
                        state_q <= S_WRITE;
                    end
                    S_WRITE: begin
                        link_q[int'(grant_q)*TIME_W +: TIME_W] <= bram_dout;
                        avail_q[grant_q] <= 1'b1;
                        // The last slot is sticky: later requests reread it.
                        if (!slot_last) begin
                            slot_q[grant_q] <= cur_slot + 1'b1;
                        end
                        if (slot_last || (bram_dout == '0)) begin
                            lane_done_q[grant_q] <= 1'b1;
                        end
                        state_q <= (enable && any_pending) ? S_ARB : S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign metadata_available = avail_q;
    assign metadata_link      = link_q;
    assign lane_done          = lane_done_q;
    assign bram_addr          = bram_addr_q;
    assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_note_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_note_fetch_scheduler
//   Directed scenarios followed by randomized request traffic. A behavioural
//   model (arrays of pending flags, slot counters and a service stage counter)
//   pushes each expected fetch result into a scoreboard queue; an independent
//   monitor pops and compares whenever the design pulses metadata_available,
//   and also compares busy, bram_addr, lane_done and metadata_link each cycle.
// -----------------------------------------------------------------------------
module tb_note_fetch_scheduler;

    localparam int N  = 37;
    localparam int LW = 6;
    localparam int SL = 4;
    localparam int TW = 16;
    localparam int AW = LW + SL;
    localparam int CW = N * TW;

    typedef logic [CW-1:0] cw_t;
    typedef struct {
        int            lane;
        logic [TW-1:0] val;
    } exp_t;
    typedef struct {
        int            lane;
        int            cyc;
        logic [TW-1:0] val;
    } seen_t;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          rewind;
    logic [N-1:0]  req;
    logic [N-1:0]  avail;
    logic [CW-1:0] link;
    logic [N-1:0]  done;
    logic [AW-1:0] addr;
    logic [TW-1:0] dout;
    logic          busy;

    logic [TW-1:0] mem [1 << AW];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t  exp_q[$];
    seen_t seen[$];

    // Reference model state
    logic [N-1:0]  m_prev;
    logic [N-1:0]  m_pend;
    logic [N-1:0]  m_done;
    logic [CW-1:0] m_link;
    int            m_slot [N];
    int            m_rr;
    int            m_stage;   // 0 idle, 1 arbitrate, 2 read, 3 write
    int            m_grant;
    int            m_addr;

    logic [TW-1:0] t2_vals [3] = '{16'd400, 16'd2000, 16'd3000};

    note_fetch_scheduler #(
        .NUM_LANES (N),
        .LANE_W    (LW),
        .SLOTS_LOG (SL),
        .TIME_W    (TW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .rewind             (rewind),
        .metadata_request   (req),
        .metadata_available (avail),
        .metadata_link      (link),
        .lane_done          (done),
        .bram_addr          (addr),
        .bram_dout          (dout),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency BRAM
    always @(posedge clk) dout <= mem[addr];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input cw_t act, input cw_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int lane);
        req[lane] = 1'b1;
        tick(1);
        req[lane] = 1'b0;
    endtask

    task automatic do_rewind();
        rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
    endtask

    // Service-level reference: one arbitrate, one read, one write step per
    // service; results come straight from the BRAM image.
    task automatic model_step();
        logic any;
        logic found;
        int   l;
        if (!rst_n) begin
            m_prev  = '0;
            m_pend  = '0;
            m_done  = '0;
            m_link  = '0;
            m_rr    = 0;
            m_stage = 0;
            m_grant = 0;
            m_addr  = 0;
            for (int i = 0; i < N; i++) m_slot[i] = 0;
            exp_q.delete();
            return;
        end
        any = |m_pend;
        if (rewind) begin
            m_pend  = '0;
            m_done  = '0;
            m_rr    = 0;
            m_stage = 0;
            for (int i = 0; i < N; i++) m_slot[i] = 0;
            m_prev = req;
            return;
        end
        case (m_stage)
            0: if (enable && any) m_stage = 1;
            1: begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    l = (m_rr + k) % N;
                    if (!found && m_pend[l]) begin
                        found   = 1'b1;
                        m_grant = l;
                    end
                end
                m_pend[m_grant] = 1'b0;
                m_addr  = m_grant * (1 << SL) + m_slot[m_grant];
                m_rr    = (m_grant + 1) % N;
                m_stage = 2;
            end
            2: m_stage = 3;
            default: begin
                exp_t e;
                e.lane = m_grant;
                e.val  = mem[m_addr];
                exp_q.push_back(e);
                m_link[m_grant*TW +: TW] = e.val;
                if (m_slot[m_grant] == (1 << SL) - 1 || e.val == '0) m_done[m_grant] = 1'b1;
                if (m_slot[m_grant] < (1 << SL) - 1) m_slot[m_grant]++;
                m_stage = (enable && any) ? 1 : 0;
            end
        endcase
        m_pend = m_pend | (req & ~m_prev);
        m_prev = req;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Monitor: compares on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            int lane;
            lane = -1;
            for (int i = N - 1; i >= 0; i--) if (avail[i]) lane = i;
            if (exp_q.size() > 0) begin
                exp_t         e;
                logic [N-1:0] oh;
                e  = exp_q.pop_front();
                oh = '0;
                oh[e.lane] = 1'b1;
                check("avail_lane", cw_t'(avail), cw_t'(oh));
                check("avail_link", cw_t'(link[e.lane*TW +: TW]), cw_t'(e.val));
            end else if (avail != '0) begin
                check("spurious_avail", cw_t'(avail), cw_t'(0));
            end
            if (lane >= 0) begin
                seen_t s;
                s.lane = lane;
                s.cyc  = cyc;
                s.val  = link[lane*TW +: TW];
                seen.push_back(s);
            end
            check("busy", cw_t'(busy), cw_t'(m_stage != 0));
            check("bram_addr", cw_t'(addr), cw_t'(m_addr));
            check("lane_done", cw_t'(done), cw_t'(m_done));
            check("link", link, m_link);
        end
    end

    initial begin
        int t_req;
        int b;

        // BRAM image: unused lanes hold a marker so stray addresses show up.
        for (int a = 0; a < (1 << AW); a++) mem[a] = 16'hDEAD;
        for (int l = 0; l < N; l++) begin
            for (int s = 0; s < (1 << SL); s++) begin
                logic [TW-1:0] v;
                v = TW'($urandom_range(1, 65535));
                if ($urandom_range(0, 7) == 0) v = '0;
                mem[l*16 + s] = v;
            end
        end
        mem[24*16 + 0] = 16'd400;
        mem[24*16 + 1] = 16'd2000;
        mem[24*16 + 2] = 16'd3000;
        mem[24*16 + 3] = 16'd0;
        for (int s = 0; s < 16; s++) mem[28*16 + s] = TW'(1000 + s);

        rst_n  = 1'b0;
        enable = 1'b0;
        rewind = 1'b0;
        req    = '0;
        tick(3);
        check("reset_avail", cw_t'(avail), cw_t'(0));
        check("reset_link",  link,         cw_t'(0));
        check("reset_done",  cw_t'(done),  cw_t'(0));
        check("reset_addr",  cw_t'(addr),  cw_t'(0));
        check("reset_busy",  cw_t'(busy),  cw_t'(0));
        rst_n = 1'b1;
        tick(2);

        // Three fetches on lane 24, each four cycles after its request edge.
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            seen.delete();
            t_req = cyc + 1;
            pulse(24);
            for (b = 0; b < 12 && seen.size() == 0; b++) tick(1);
            check("t2_count", cw_t'(seen.size()), cw_t'(1));
            if (seen.size() > 0) begin
                check("t2_value",   cw_t'(seen[0].val),         cw_t'(t2_vals[k]));
                check("t2_latency", cw_t'(seen[0].cyc - t_req), cw_t'(4));
            end
            tick(3);
        end

        // Simultaneous requests: round-robin order, three cycles apart.
        do_rewind();
        for (int r = 0; r < 2; r++) begin
            int order [4] = '{24, 26, 28, 31};
            seen.delete();
            req[24] = 1'b1; req[26] = 1'b1; req[28] = 1'b1; req[31] = 1'b1;
            tick(1);
            req = '0;
            for (b = 0; b < 30 && seen.size() < 4; b++) tick(1);
            check("t3_count", cw_t'(seen.size()), cw_t'(4));
            for (int k = 0; k < 4 && k < seen.size(); k++) begin
                check("t3_order", cw_t'(seen[k].lane), cw_t'(order[k]));
                if (k > 0) check("t3_spacing", cw_t'(seen[k].cyc - seen[k-1].cyc), cw_t'(3));
            end
            tick(3);
        end

        // A held level requests only once.
        seen.delete();
        req[26] = 1'b1;
        tick(50);
        req[26] = 1'b0;
        tick(10);
        check("t4_single_pulse", cw_t'(seen.size()), cw_t'(1));

        // Lane 28 saturates at entry 15.
        do_rewind();
        seen.delete();
        for (int k = 0; k < 17; k++) begin
            pulse(28);
            tick(6);
            if (k == 14) check("t5_not_done", cw_t'(done[28]), cw_t'(0));
            if (k == 15) check("t5_done",     cw_t'(done[28]), cw_t'(1));
        end
        check("t5_count", cw_t'(seen.size()), cw_t'(17));
        if (seen.size() == 17) check("t5_repeat_last", cw_t'(seen[16].val), cw_t'(1015));

        // enable low: requests accumulate but nothing is serviced.
        seen.delete();
        enable = 1'b0;
        pulse(3);
        pulse(10);
        pulse(36);
        tick(10);
        check("t6_idle_busy", cw_t'(busy), cw_t'(0));
        check("t6_no_service", cw_t'(seen.size()), cw_t'(0));
        enable = 1'b1;
        tick(15);
        check("t6_three_services", cw_t'(seen.size()), cw_t'(3));

        // rewind while a read is in flight aborts it.
        seen.delete();
        pulse(5);
        for (b = 0; b < 10 && m_stage != 2; b++) tick(1);
        check("t6_reached_read", cw_t'(busy), cw_t'(1));
        do_rewind();
        check("t6_rewind_busy", cw_t'(busy), cw_t'(0));
        tick(8);
        check("t6_aborted", cw_t'(seen.size()), cw_t'(0));
        pulse(5);
        tick(8);
        check("t6_slot_restart_count", cw_t'(seen.size()), cw_t'(1));
        if (seen.size() > 0) check("t6_slot_restart", cw_t'(seen[0].val), cw_t'(mem[5*16]));

        // Reset in the middle of a write.
        seen.delete();
        pulse(7);
        for (b = 0; b < 10 && m_stage != 3; b++) tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_avail", cw_t'(avail), cw_t'(0));
        check("t1_link",  link,         cw_t'(0));
        check("t1_done",  cw_t'(done),  cw_t'(0));
        check("t1_addr",  cw_t'(addr),  cw_t'(0));
        check("t1_busy",  cw_t'(busy),  cw_t'(0));
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("t1_no_pulse_after_reset", cw_t'(seen.size()), cw_t'(0));

        // Randomized traffic with enable gaps and occasional rewinds.
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < N; l++) if ($urandom_range(0, 63) == 0) req[l] = ~req[l];
            enable = ($urandom_range(0, 19) != 0);
            rewind = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        req    = '0;
        rewind = 1'b0;
        enable = 1'b1;
        for (b = 0; b < 600 && !(m_stage == 0 && m_pend == '0); b++) tick(1);
        tick(4);
        check("drain_scoreboard_empty", cw_t'(exp_q.size()), cw_t'(0));
        check("drain_idle", cw_t'(busy), cw_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
